// File: rtl/inst_fetch.sv
// inst_fetch: MIPS instruction-fetch stage in front of a combinational
// instruction memory. Owns the PC, captures the returned word into an IF/ID
// register and hands it to decode. Handles redirects, decode back-pressure
// and address faults (misaligned redirect target, fetch past end of memory).
//
// Optional feature macro: INST_FETCH_DELAY_SLOT_EN
//   defined     -> MIPS delay-slot semantics: the word at the current pc is
//                  still delivered when a redirect is accepted.
//   not defined -> the word at the current pc is squashed on a redirect
//                  (one bubble per taken redirect).
//
// Handshake toward decode (id_*): the IF/ID register presents an instruction
// while id_valid=1; it is consumed on a rising edge where id_valid=1 and
// id_ready=1. While id_valid=1 and id_ready=0, id_instr/id_pc/id_pc4 are held
// stable. id_valid never depends combinationally on id_ready.
//
// Redirect handshake: redirect_valid/redirect_target are sampled only on an
// edge where the IF/ID register is free to advance; otherwise the request is
// ignored and the source must keep holding it.
//
// dbg_state exposes the FSM state (0 = RUN, 1 = HALT).
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic        dbg_state
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Highest byte address at which a full word can still be fetched.
    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

`ifdef INST_FETCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic        r_fault;
    logic [31:0] r_fault_pc;

    logic        w_advance;
    logic        w_out_of_range;
    logic        w_target_misaligned;
    logic [31:0] w_pc_plus4;

    // IF/ID register is empty or being drained this cycle, so it may load.
    assign w_advance           = !r_id_valid || id_ready;
    // Compared before pc+4 is ever used, so a wrap past 2^32 never escapes.
    assign w_out_of_range      = r_pc > LAST_PC;
    assign w_target_misaligned = redirect_target[1:0] != 2'b00;
    assign w_pc_plus4          = r_pc + 32'd4;

    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign id_pc4    = r_id_pc4;
    assign fault     = r_fault;
    assign fault_pc  = r_fault_pc;
    assign dbg_state = (r_state == ST_HALT);

    // Fetch FSM: PC sequencing, IF/ID capture, redirect and fault handling.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= 32'd0;
            r_id_pc    <= 32'd0;
            r_id_pc4   <= 32'd0;
            r_fault    <= 1'b0;
            r_fault_pc <= 32'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_advance) begin
                        if (w_out_of_range) begin
                            // Fetch address past the end of memory: stop here.
                            r_fault    <= 1'b1;
                            r_fault_pc <= r_pc;
                            r_id_valid <= 1'b0;
                            r_state    <= ST_HALT;
                        end else if (redirect_valid) begin
                            // Word at the current pc is the delay slot.
                            if (DELAY_SLOT) begin
                                r_id_instr <= imem_data;
                                r_id_pc    <= r_pc;
                                r_id_pc4   <= w_pc_plus4;
                                r_id_valid <= 1'b1;
                            end else begin
                                r_id_valid <= 1'b0;
                            end
                            if (w_target_misaligned) begin
                                r_fault    <= 1'b1;
                                r_fault_pc <= redirect_target;
                                r_state    <= ST_HALT;
                            end else begin
                                r_pc <= redirect_target;
                            end
                        end else begin
                            r_id_instr <= imem_data;
                            r_id_pc    <= r_pc;
                            r_id_pc4   <= w_pc_plus4;
                            r_id_valid <= 1'b1;
                            r_pc       <= w_pc_plus4;
                        end
                    end
                end
                ST_HALT: begin
                    // Only a delivered delay-slot word can still be pending.
                    if (r_id_valid && id_ready) begin
                        r_id_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by randomized traffic.
// Expected deliveries are pushed into exp_q by the stimulus side and popped
// by a monitor when the DUT completes a handshake toward decode.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        fault;
  logic [31:0] fault_pc;
  logic        dbg_state;

`ifdef INST_FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0), .IMEM_BYTES(512)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4),
    .fault(fault), .fault_pc(fault_pc), .dbg_state(dbg_state)
  );

  // ---------------- instruction memory ----------------
  logic [31:0] mem [0:127];
  assign imem_data = (imem_addr < 32'd512) ? mem[imem_addr[8:2]] : 32'hDEAD_BEEF;

  // ---------------- reference model ----------------
  // m_* is the state after the next rising edge, cur_* the state now visible.
  logic [31:0] m_pc, m_fault_pc, cur_pc, cur_fault_pc;
  bit          m_valid, m_fault, m_halt, m_clean;
  bit          cur_valid, cur_fault, cur_halt, cur_clean;
  logic [63:0] exp_q[$];   // {pc, instr}
  bit          mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_fault = 0; m_fault_pc = 32'h0;
    m_halt = 0; m_clean = 1;
    exp_q.delete();
  endtask

  task automatic model_deliver();
    exp_q.push_back({m_pc, mem[m_pc[8:2]]});
    m_valid = 1;
    m_clean = 0;
  endtask

  task automatic model_fault(input logic [31:0] addr);
    m_fault = 1; m_fault_pc = addr; m_halt = 1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rdy, input bit rn, input bit rv,
                      input logic [31:0] rt, output bit acc);
    @(posedge clk); #1;
    acc = 0;
    reset_n = rn;
    id_ready = rn ? rdy : 1'b0;
    redirect_valid = rv;
    redirect_target = rt;
    cur_pc = m_pc; cur_valid = m_valid; cur_fault = m_fault;
    cur_fault_pc = m_fault_pc; cur_halt = m_halt; cur_clean = m_clean;
    if (!rn) begin
      model_reset();
    end else if (m_halt) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (!m_valid || rdy) begin
      if (m_pc > 32'd508) begin
        model_fault(m_pc);
        m_valid = 0;
      end else if (rv) begin
        acc = 1;
        if (DS) model_deliver();
        else m_valid = 0;
        if (rt % 4 != 0) model_fault(rt);
        else m_pc = rt;
      end else begin
        model_deliver();
        m_pc = m_pc + 4;
      end
    end
  endtask

  task automatic run(input bit rdy, input int n);
    bit a;
    for (int i = 0; i < n; i++) step(rdy, 1'b1, 1'b0, 32'h0, a);
  endtask

  task automatic redirect(input bit rdy, input logic [31:0] rt);
    bit a;
    step(rdy, 1'b1, 1'b1, rt, a);
  endtask

  task automatic do_reset();
    bit a;
    step(1'b0, 1'b0, 1'b0, 32'h0, a);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [63:0] e;
      check32("imem_addr", imem_addr, cur_pc);
      check32("id_valid", {31'd0, id_valid}, {31'd0, cur_valid});
      check32("fault", {31'd0, fault}, {31'd0, cur_fault});
      check32("halt_state", {31'd0, dbg_state}, {31'd0, cur_halt});
      check32("fault_pc", fault_pc, cur_fault ? cur_fault_pc : 32'h0);
      if (cur_clean) begin
        check32("id_instr_rst", id_instr, 32'h0);
        check32("id_pc_rst", id_pc, 32'h0);
        check32("id_pc4_rst", id_pc4, 32'h0);
      end
      if (id_valid && id_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery actual_pc=%h required=none", id_pc);
        end else begin
          e = exp_q.pop_front();
          check32("id_pc", id_pc, e[63:32]);
          check32("id_instr", id_instr, e[31:0]);
          check32("id_pc4", id_pc4, e[63:32] + 32'd4);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit acc, rv, rdy, rn;
    logic [31:0] rt;
    int halt_cnt;
    int r;

    for (int i = 0; i < 128; i++) mem[i] = $urandom();
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0010;
    mem[2] = 32'h200a_0020;

    reset_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    model_reset();
    do_reset();
    do_reset();
    mon_en = 1'b1;

    // Sequential fetch, then stall holding id_pc=4, then resume.
    run(1'b1, 2);
    run(1'b0, 3);
    run(1'b1, 2);
    // Walk to pc=0x10 and redirect to 0x18.
    for (int i = 0; i < 8 && m_pc != 32'h10; i++) run(1'b1, 1);
    redirect(1'b1, 32'h18);
    run(1'b1, 3);
    // Redirect presented during a stall is ignored until id_ready rises.
    redirect(1'b0, 32'h40);
    redirect(1'b0, 32'h40);
    redirect(1'b1, 32'h40);
    run(1'b1, 2);
    // Misaligned redirect faults and halts; pc frozen.
    redirect(1'b1, 32'h1A);
    run(1'b1, 4);
    run(1'b0, 2);
    do_reset();
    run(1'b1, 3);
    // Sequential fetch running off the end of memory.
    redirect(1'b1, 32'h1F8);
    run(1'b1, 5);
    // Reset from HALT, then reset in the middle of a stall.
    do_reset();
    run(1'b1, 2);
    run(1'b0, 2);
    do_reset();
    run(1'b1, 3);

    // Randomized traffic; a pending redirect is held until accepted.
    rv = 0; rt = 32'h0; halt_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!rv && $urandom_range(0, 99) < 12) begin
        rv = 1;
        r = $urandom_range(0, 99);
        if (r < 5)       rt = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
        else if (r < 25) rt = 32'h1E0 + 4 * $urandom_range(0, 7);
        else if (r < 30) rt = 32'h200 + 4 * $urandom_range(0, 255);
        else             rt = 4 * $urandom_range(0, 127);
      end
      rdy = ($urandom_range(0, 99) < 70);
      rn = !(m_halt && halt_cnt > 4) && ($urandom_range(0, 99) >= 2);
      step(rdy, rn, rv, rt, acc);
      if (acc || !rn) rv = 0;
      halt_cnt = m_halt ? halt_cnt + 1 : 0;
    end
    run(1'b1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
